// File: rtl/segdis_mux_if.sv
// Bus bundle for the multiplexed seven-segment display driver.
// Host side (master) loads digits and levels; the driver (slave) returns pin levels and status.
interface segdis_mux_if #(
    parameter int NDIG = 4
);
    logic                load;
    logic [4*NDIG-1:0]   data_in;
    logic [NDIG-1:0]     dp_in;
    logic                lz_en;
    logic                en;
    logic [6:0]          seg;
    logic                dp;
    logic [NDIG-1:0]     an;
    logic                pend;
    logic                frame;

    modport master (
        output load, data_in, dp_in, lz_en, en,
        input  seg, dp, an, pend, frame
    );

    modport slave (
        input  load, data_in, dp_in, lz_en, en,
        output seg, dp, an, pend, frame
    );
endinterface

// File: rtl/segdis_mux.sv
// Time-multiplexed hex display driver: prescaled digit scan, shadow/active
// double buffer applied at frame wrap, leading-zero blanking, pin polarity options.
module segdis_mux #(
    parameter int NDIG    = 4,
    parameter int DIV     = 1000,
    parameter int SEG_LOW = 0,
    parameter int AN_LOW  = 0
) (
    input logic          clk,
    input logic          rst_n,
    segdis_mux_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [PW-1:0]      r_pre;
    logic [IW-1:0]      r_idx;
    logic [4*NDIG-1:0]  r_shd_d;
    logic [4*NDIG-1:0]  r_act_d;
    logic [NDIG-1:0]    r_shd_dp;
    logic [NDIG-1:0]    r_act_dp;
    logic               r_pend;
    logic               r_frame;

    logic               w_tick;
    logic               w_wrap;
    logic               w_apply;
    logic [3:0]         w_nib;
    logic               w_dpbit;
    logic               w_hi_zero;
    logic               w_blank;
    logic [6:0]         w_seg;
    logic               w_dp;
    logic [NDIG-1:0]    w_an;

    function automatic logic [6:0] f_seg7(input logic [3:0] n);
        case (n)
            4'h0: f_seg7 = 7'h3F;
            4'h1: f_seg7 = 7'h06;
            4'h2: f_seg7 = 7'h5B;
            4'h3: f_seg7 = 7'h4F;
            4'h4: f_seg7 = 7'h66;
            4'h5: f_seg7 = 7'h6D;
            4'h6: f_seg7 = 7'h7D;
            4'h7: f_seg7 = 7'h07;
            4'h8: f_seg7 = 7'h7F;
            4'h9: f_seg7 = 7'h6F;
            4'hA: f_seg7 = 7'h77;
            4'hB: f_seg7 = 7'h7C;
            4'hC: f_seg7 = 7'h39;
            4'hD: f_seg7 = 7'h5E;
            4'hE: f_seg7 = 7'h79;
            default: f_seg7 = 7'h71;
        endcase
    endfunction

    assign w_tick  = (r_pre == PW'(DIV - 1));
    assign w_wrap  = w_tick && (r_idx == IW'(NDIG - 1));
    assign w_apply = w_wrap && r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end
            r_frame <= w_wrap;
        end
    end

    // Active copy takes the old shadow on the apply edge even if a new load lands then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd_d  <= '0;
            r_shd_dp <= '0;
            r_act_d  <= '0;
            r_act_dp <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_d  <= r_shd_d;
                r_act_dp <= r_shd_dp;
            end
            if (bus.load) begin
                r_shd_d  <= bus.data_in;
                r_shd_dp <= bus.dp_in;
            end
            r_pend <= bus.load | (r_pend & ~w_wrap);
        end
    end

    // Blank when the current nibble and every nibble above it are zero.
    always_comb begin
        w_nib     = '0;
        w_dpbit   = 1'b0;
        w_hi_zero = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib   = r_act_d[4*i +: 4];
                w_dpbit = r_act_dp[i];
            end
            if ((IW'(i) >= r_idx) && (r_act_d[4*i +: 4] != 4'h0)) begin
                w_hi_zero = 1'b0;
            end
        end
        w_blank = bus.lz_en && (r_idx != '0) && w_hi_zero;
        w_seg   = '0;
        w_dp    = 1'b0;
        w_an    = '0;
        if (bus.en) begin
            w_seg = w_blank ? 7'h00 : f_seg7(w_nib);
            w_dp  = w_dpbit;
            w_an  = NDIG'(1) << r_idx;
        end
    end

    assign bus.seg   = (SEG_LOW != 0) ? ~w_seg : w_seg;
    assign bus.dp    = (SEG_LOW != 0) ? ~w_dp  : w_dp;
    assign bus.an    = (AN_LOW  != 0) ? ~w_an  : w_an;
    assign bus.pend  = r_pend;
    assign bus.frame = r_frame;
endmodule

// File: doc/segdis_mux.md
SEGDIS_MUX -- requirements
Module: segdis_mux

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIV, default 1000: clocks per digit slot; legal range >= 1.
REQ-003 Parameter SEG_LOW, default 0: 1 inverts seg and dp at the pins.
REQ-004 Parameter AN_LOW, default 0: 1 inverts an at the pins.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 load  in  1  single-cycle strobe; captures data_in and dp_in.
REQ-008 data_in  in  4*NDIG  hex nibbles; nibble i drives digit i; digit 0 is least significant.
REQ-009 dp_in  in  NDIG  decimal point per digit.
REQ-010 lz_en  in  1  leading-zero suppression enable; level input, not latched.
REQ-011 en  in  1  display enable; 0 turns off all anodes.
REQ-012 seg  out  7  segments {g,f,e,d,c,b,a}; bit0 = a.
REQ-013 dp  out  1  decimal point of the current digit.
REQ-014 an  out  NDIG  one-hot digit select.
REQ-015 pend  out  1  loaded value captured but not yet displayed.
REQ-016 frame  out  1  one-cycle pulse when the scan wraps from digit NDIG-1 to digit 0.

Function
REQ-017 The prescaler counts 0..DIV-1 and wraps to 0; tick = (prescaler == DIV-1); with DIV=1, tick is asserted every cycle.
REQ-018 The digit index idx advances by 1 on each tick and wraps from NDIG-1 to 0.
REQ-019 frame is asserted in the cycle after the edge on which idx wraps to 0; it is a registered one-cycle pulse.
REQ-020 load=1 captures data_in and dp_in into the shadow register and sets pend=1 on the same edge; a later load before apply overwrites the shadow (last load wins).
REQ-021 Apply: on the edge where idx wraps to 0 with pend=1, the shadow copies into the active register and pend clears (tear-free update).
REQ-022 Simultaneous load and apply: the active register takes the old shadow contents, the shadow takes the new data_in, and pend stays 1.
REQ-023 Outputs an, seg and dp are combinational from registered idx, the active register, en and lz_en; they have no further latency.
REQ-024 an: bit idx = 1 and all other bits = 0 when en=1; all bits = 0 when en=0; AN_LOW inverts all bits.
REQ-025 Decode of the active nibble (hex) to {g..a}:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71
REQ-026 Leading-zero suppression: with lz_en=1, digit i>0 is blanked (seg=00) when nibble i and every higher nibble are 0; digit 0 is never blanked.
REQ-027 dp = active dp bit of digit idx and is unaffected by blanking; seg=00 and dp=0 when en=0; SEG_LOW inverts seg and dp.
REQ-028 Changing en does not stop the prescaler or idx.

Reset
REQ-029 rst_n=0 asynchronously clears the prescaler, idx, shadow, active register, pend and frame.
REQ-030 During reset, with en=1 and SEG_LOW=AN_LOW=0: an = one-hot bit 0, seg=3F, dp=0.
REQ-031 A pending load is discarded on reset.
REQ-032 Scanning resumes on the first rising clk edge after rst_n is released.

Verification
REQ-033 NDIG=4, DIV=4, load data_in=0x1234, dp_in=0 -> pend=1 until the next wrap, then the scan shows digit0 seg=66, digit1 4F, digit2 5B, digit3 06, with each an slot lasting 4 cycles.
REQ-034 Two loads, 0x1111 then 0x2222, within one frame -> after the wrap the active register = 0x2222 and 0x1111 is never displayed.
REQ-035 Load asserted on the apply edge (shadow 0xAAAA, new 0xBBBB) -> active=0xAAAA and pend=1; the next wrap shows 0xBBBB and pend=0.
REQ-036 lz_en=1, data=0x0050 -> digits 3 and 2 give seg=00, digit 1 gives 6D, digit 0 gives 3F; with data=0x0000 only digit 0 lights, showing 3F.
REQ-037 en=0 -> an=0, seg=00 and dp=0 while idx keeps counting; en=1 resumes at the correct idx with no phase loss.
REQ-038 rst_n pulsed low mid-frame with pend=1 -> all registers clear immediately and pend=0; DIV=1 gives frame every NDIG cycles.
